channel_loader: RTL

CHANNEL_LOADER -- requirements
Module: channel_loader

---
 rtl/polar_pkg.sv | 17 +
 rtl/channel_loader_if.sv | 32 +++
 rtl/llr_sat.sv | 26 ++
 rtl/channel_loader.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// Shared frame geometry and controller state encoding for the channel loader.
package polar_pkg;

   localparam int N     = 1024;   // LLRs per frame
   localparam int P     = 64;     // LLR lanes per packed word
   localparam int Q     = 6;      // stored LLR width
   localparam int IN_W  = 8;      // incoming LLR width
   localparam int WORDS = N / P;  // packed words per frame
   localparam int CNT_W = 5;      // width of the word-index output

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/channel_loader_if.sv
// Serial LLR input, packed-word output and frame control signals of the loader.
interface channel_loader_if #(
   parameter int P    = polar_pkg::P,
   parameter int Q    = polar_pkg::Q,
   parameter int IN_W = polar_pkg::IN_W
) ();

   logic                          start;
   logic                          abort;
   logic                          in_valid;
   logic signed [IN_W-1:0]        in_llr;
   logic                          in_ready;
   logic [P*Q-1:0]                W_channel;
   logic [polar_pkg::CNT_W-1:0]   channel_count;
   logic                          channel_ready;
   logic                          channel;
   logic                          decode_done;
   logic                          frame_loaded;

   // Side that feeds samples and controls the frame (host / decoder)
   modport master (
      output start, abort, in_valid, in_llr, decode_done,
      input  in_ready, W_channel, channel_count, channel_ready, channel, frame_loaded
   );

   // Side implemented by the loader
   modport slave (
      input  start, abort, in_valid, in_llr, decode_done,
      output in_ready, W_channel, channel_count, channel_ready, channel, frame_loaded
   );

endinterface

// File: rtl/llr_sat.sv
// Symmetric saturation of an IN_W-bit LLR to Q bits; the most negative code is
// never produced so the stored range is +-(2^(Q-1)-1).
module llr_sat #(
   parameter int IN_W = 8,
   parameter int Q    = 6
) (
   input  logic signed [IN_W-1:0] llr_i,
   output logic signed [Q-1:0]    llr_o
);

   localparam int                     MAXI = (1 << (Q - 1)) - 1;
   localparam logic signed [IN_W-1:0] HI   = IN_W'(MAXI);
   localparam logic signed [IN_W-1:0] LO   = IN_W'(-MAXI);

   // Clamp to the symmetric range, otherwise pass the low Q bits through
   always_comb begin
      if (llr_i > HI) begin
         llr_o = HI[Q-1:0];
      end else if (llr_i < LO) begin
         llr_o = LO[Q-1:0];
      end else begin
         llr_o = llr_i[Q-1:0];
      end
   end

endmodule

// File: rtl/channel_loader.sv
// Channel loader: packs a serial stream of saturated LLRs into P-lane words,
// strobes each completed word to the decoder storage and hands ownership of
// the storage to the decoder once the whole frame is written.
module channel_loader #(
   parameter int N    = polar_pkg::N,
   parameter int P    = polar_pkg::P,
   parameter int Q    = polar_pkg::Q,
   parameter int IN_W = polar_pkg::IN_W
) (
   input  logic            clk,
   input  logic            rst,
   channel_loader_if.slave bus
);

   import polar_pkg::state_e;
   import polar_pkg::IDLE;
   import polar_pkg::FILL;
   import polar_pkg::RUN;
   import polar_pkg::CNT_W;

   localparam int WORDS  = N / P;
   localparam int LANE_W = (P > 1) ? $clog2(P) : 1;
   localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_e              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [WORD_W-1:0]   wcnt_q, wcnt_d;
   logic [P*Q-1:0]      pack_q, pack_d;
   logic [P*Q-1:0]      wchan_q;
   logic [CNT_W-1:0]    ccnt_q;
   logic                crdy_q;
   logic                chan_q, chan_d;
   logic                fl_q, fl_d;

   logic signed [Q-1:0] sat_llr;
   logic                in_ready;
   logic                accept;
   logic                lane_last;
   logic                word_last;

   llr_sat #(
      .IN_W (IN_W),
      .Q    (Q)
   ) u_sat (
      .llr_i (bus.in_llr),
      .llr_o (sat_llr)
   );

   assign lane_last = (lane_q == LANE_W'(P - 1));
   assign word_last = (wcnt_q == WORD_W'(WORDS - 1));

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; abort outranks start, the final acceptance and decode_done
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.start && !bus.abort) state_d = FILL;
         FILL: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (accept && lane_last && word_last) begin
               state_d = RUN;
            end
         end
         RUN:  if (bus.abort || bus.decode_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: input handshake, storage ownership and the frame-done pulse
   always_comb begin
      in_ready = (state_q == FILL);
      accept   = in_ready && bus.in_valid && !bus.abort;
      // channel rises the cycle after the last strobe and stays up while RUN lasts
      chan_d   = (state_q == RUN) && (state_d == RUN);
      // the only strobe seen while in RUN is the one for the last word
      fl_d     = crdy_q && chan_d;
   end

   // Lane/word counters: cleared on a new frame or abort, word index saturates
   always_comb begin
      lane_d = lane_q;
      wcnt_d = wcnt_q;
      if ((state_q == IDLE && bus.start) || bus.abort) begin
         lane_d = '0;
         wcnt_d = '0;
      end else if (accept) begin
         if (lane_last) begin
            lane_d = '0;
            if (!word_last) wcnt_d = wcnt_q + 1'b1;
         end else begin
            lane_d = lane_q + 1'b1;
         end
      end
   end

   // Word under assembly with the current sample merged into its lane
   always_comb begin
      pack_d = pack_q;
      pack_d[int'(lane_q) * Q +: Q] = sat_llr;
   end

   // Assembly buffer; every lane is rewritten before it is ever published
   always_ff @(posedge clk) begin
      if (accept) pack_q <= pack_d;
   end

   // Counters and published outputs; word/index are held between strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_q  <= '0;
         wcnt_q  <= '0;
         wchan_q <= '0;
         ccnt_q  <= '0;
         crdy_q  <= 1'b0;
         chan_q  <= 1'b0;
         fl_q    <= 1'b0;
      end else begin
         lane_q <= lane_d;
         wcnt_q <= wcnt_d;
         crdy_q <= accept && lane_last;
         if (accept && lane_last) begin
            wchan_q <= pack_d;
            ccnt_q  <= CNT_W'(wcnt_q);
         end
         chan_q <= chan_d;
         fl_q   <= fl_d;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.W_channel     = wchan_q;
   assign bus.channel_count = ccnt_q;
   assign bus.channel_ready = crdy_q;
   assign bus.channel       = chan_q;
   assign bus.frame_loaded  = fl_q;

endmodule
